// File: rtl/mem_lsu_serial.sv
// MEM-stage load/store unit: serialises byte/half/word accesses onto a narrow memory port.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_lsu_serial #(
    parameter int unsigned MEM_BYTES = 1,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [1:0]             req_sel_i,
    input  logic                   req_sign_i,
    input  logic [31:0]            req_addr_i,
    input  logic [31:0]            req_wdata_i,
    input  logic [4:0]             req_rd_i,
    output logic                   resp_valid_o,
    output logic                   resp_wreg_o,
    output logic [4:0]             resp_rd_o,
    output logic [31:0]            resp_wdata_o,
    output logic                   misalign_o,
    output logic                   stall_o,
    output logic                   mem_ce_o,
    output logic                   mem_we_o,
    output logic [MEM_BYTES-1:0]   mem_be_o,
    output logic [31:0]            mem_addr_o,
    output logic [8*MEM_BYTES-1:0] mem_wdata_o,
    input  logic [8*MEM_BYTES-1:0] mem_rdata_i
);
    localparam int unsigned MW = 8 * MEM_BYTES;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [2:0]  lat_q, lat_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic        sign_q, sign_d;
    logic        mis_q, mis_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [4:0]  rd_q, rd_d;

    logic [2:0]  size_c;
    logic [2:0]  off_c;
    logic        last_c;
    logic        mis_c;
    logic [31:0] ext_c;

    function automatic logic [2:0] size_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Byte offset of the current beat within the request and last-beat detect
    assign size_c = size_of(sel_q);
    assign off_c  = 3'(32'(beat_q) * MEM_BYTES);
    assign last_c = ({1'b0, off_c} + 4'(MEM_BYTES)) >= {1'b0, size_c};

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_c = ((req_sel_i == 2'd1) && req_addr_i[0]) ||
                   ((req_sel_i == 2'd2) && (req_addr_i[1:0] != 2'b00));
`else
    assign mis_c = 1'b0;
`endif

    always_comb begin
        case (sel_q)
            2'd0:    ext_c = {{24{sign_q & buf_q[7]}}, buf_q[7:0]};
            2'd1:    ext_c = {{16{sign_q & buf_q[15]}}, buf_q[15:0]};
            default: ext_c = buf_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            sign_q  <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            sign_q  <= sign_d;
            mis_q   <= mis_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        logic [2:0] idx;
        idx          = '0;
        state_d      = state_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        we_d         = we_q;
        sel_d        = sel_q;
        sign_d       = sign_q;
        mis_d        = mis_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        rd_d         = rd_q;
        req_ready_o  = 1'b0;
        stall_o      = 1'b0;
        resp_valid_o = 1'b0;
        resp_wreg_o  = 1'b0;
        resp_rd_o    = '0;
        resp_wdata_o = '0;
        misalign_o   = 1'b0;
        mem_ce_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                stall_o     = req_valid_i;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    sign_d  = req_sign_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rd_d    = req_rd_i;
                    mis_d   = mis_c;
                    beat_d  = '0;
                    lat_d   = '0;
                    buf_d   = '0;
                    state_d = ((req_sel_i == 2'd3) || mis_c) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                stall_o    = 1'b1;
                mem_ce_o   = 1'b1;
                mem_addr_o = addr_q + 32'(off_c);
                for (int j = 0; j < int'(MEM_BYTES); j++) begin
                    mem_be_o[j] = ({1'b0, off_c} + 4'(j)) < {1'b0, size_c};
                end
                if (we_q) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = MW'(wdata_q >> {off_c, 3'b000});
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    lat_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (lat_q == 3'(READ_LAT - 1)) begin
                    // Lane j of the beat lands in request byte off+j
                    for (int j = 0; j < int'(MEM_BYTES); j++) begin
                        idx = off_c + 3'(j);
                        if (idx < size_c) begin
                            buf_d[{idx[1:0], 3'b000} +: 8] = mem_rdata_i[8*j +: 8];
                        end
                    end
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            DONE: begin
                resp_valid_o = 1'b1;
                resp_rd_o    = rd_q;
                misalign_o   = mis_q;
                resp_wreg_o  = !we_q && (sel_q != 2'd3) && !mis_q;
                resp_wdata_o = (!we_q && (sel_q != 2'd3) && !mis_q) ? ext_c : 32'h0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
